round_key_reader: RTL and testbench
===================================

Name: round_key_reader

Overview:
- Reads expanded round-key words back out of the key memory and streams them byte-serially to the 8-bit AES datapath.
- It is the read-side counterpart to key expansion, which writes 32-bit words into that memory.
- Supports forward order (encryption) and reverse round order (decryption).
- Uses a 2-entry word prefetch buffer, so the datapath sees one byte per cycle without bubbles while ready is held high.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; the block streams NUM_ROUNDS+1 round keys, 4 words each
ADDR_W, 6, key memory word-address width; must satisfy 2^ADDR_W >= 4*(NUM_ROUNDS+1)

Ports:
gated_clk_ff  input  1  clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a sweep; ignored while busy=1
decrypt  input  1  sampled when start is accepted; 0 = rounds 0..NUM_ROUNDS, 1 = rounds NUM_ROUNDS..0
abort  input  1  synchronous clear to IDLE; drops buffered and in-flight words
mem_rd_en  output  1  key memory read strobe
mem_addr  output  ADDR_W  key memory word address
mem_rd_data  input  32  read data, valid exactly 1 cycle after mem_rd_en
rk_byte  output  8  round-key byte
rk_valid  output  1  rk_byte is valid
rk_ready  input  1  datapath accepts the byte when rk_valid && rk_ready
rk_last  output  1  marks byte 15 of the current round key
round_cnt  output  4  round index of the byte currently presented
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst=0, async): FSM=IDLE, both buffer entries empty, in-flight cleared. All outputs 0, including mem_addr, rk_byte and round_cnt.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DRAIN once the last word read has been issued.
  - DRAIN -> DONE once the last byte is accepted.
  - DONE -> IDLE after 1 cycle; done=1 only in DONE.
- busy=1 in RUN and DRAIN.
- Address sequence, for round r word w (w=0..3): mem_addr = 4*r + w.
  - Encrypt: r = 0..NUM_ROUNDS.
  - Decrypt: r = NUM_ROUNDS down to 0.
  - Within a round, w is always ascending.
- Read issue: mem_rd_en=1 in a cycle iff (occupied entries + in-flight reads) < 2 and words remain. At most one read is issued per cycle.
  - The first read is issued in the cycle after start is accepted.
  - The returned word is written into the buffer on the cycle mem_rd_data is valid.
- Serialisation: the head word is emitted MSB first: bits [31:24], [23:16], [15:8], [7:0].
  - A 2-bit byte counter advances on each handshake.
  - The head entry is popped on the 4th handshake.
  - A word that arrives in the same cycle as a pop is written without loss.
- Latency: rk_valid first rises 2 cycles after start is accepted.
  - With rk_ready held high, 16*(NUM_ROUNDS+1) consecutive bytes follow with no gaps.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_byte, rk_last and round_cnt hold stable.
  - Reads stall once the buffer plus in-flight count reaches 2; no word is ever dropped.
- round_cnt updates on the handshake of rk_last. rk_last is high only for byte 15 of each round.
- abort (synchronous, highest priority): next cycle is IDLE with the buffer emptied.
  - A read return that was in flight during abort is discarded.
  - done is not pulsed.
  - abort together with start: abort wins and the start is dropped.
- start while busy=1 is ignored; a sweep cannot be restarted without abort.
- Async reset mid-sweep returns the block to reset values immediately.

Optional Feature:
RK_XOR_CHECKSUM_EN
- Defined:
  - Adds output rk_checksum[7:0], the running XOR of every byte accepted in the current sweep.
  - It is cleared when start is accepted and held stable from DONE until the next start.
  - It is cleared by abort and by reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
All cases use memory model mem[i] = {4i, 4i+1, 4i+2, 4i+3} (bytes mod 256) and NUM_ROUNDS=10.
- Encrypt, rk_ready=1: start, decrypt=0 -> rk_valid rises 2 cycles later; 176 bytes 0x00..0xAF with no gaps; rk_last on 0x0F, 0x1F, ..., 0xAF; done 1 cycle after 0xAF; rk_checksum=0x00.
- Decrypt, rk_ready=1 -> first round bytes 0xA0..0xAF with round_cnt=10; next round 0x90..0x9F; last byte 0x0F with round_cnt=0; mem_addr order 40,41,42,43,36,...,3.
- Backpressure: rk_ready toggled 1 cycle on / 3 cycles off, and held low for 20 cycles mid-word -> byte stream identical to the first case; rk_byte stable while stalled; never more than 2 words held or in flight.
- abort at byte 37 with a read in flight -> IDLE next cycle; rk_valid=0; no done; a following encrypt start restarts at 0x00.
- start asserted at byte 50 while busy -> ignored; the sweep completes normally with 176 bytes.
- rst driven low mid-sweep, asynchronously with no clock edge -> all outputs 0 at once; after release, the block is idle until start.

Source files
------------

// File: rtl/round_key_reader_if.sv
// Bus bundle for round_key_reader: key-memory read port plus the byte-serial
// round-key stream towards the AES datapath.
//   master : the reader side (drives the memory strobe/address and the stream)
//   slave  : the environment side (memory read data and datapath ready)
interface round_key_reader_if #(
  parameter int ADDR_W = 6
);
  // Key memory read port
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;

  // Round-key byte stream
  logic [7:0]        rk_byte;
  logic              rk_valid;
  logic              rk_ready;
  logic              rk_last;
  logic [3:0]        round_cnt;

  modport master (
    output mem_rd_en, mem_addr, rk_byte, rk_valid, rk_last, round_cnt,
    input  mem_rd_data, rk_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, rk_byte, rk_valid, rk_last, round_cnt,
    output mem_rd_data, rk_ready
  );
endinterface

// File: rtl/round_key_reader.sv
// round_key_reader: reads expanded round-key words from the key memory and
// streams them MSB-first, one byte per handshake, to the 8-bit AES datapath.
// Forward round order for encryption, reverse round order for decryption.
// A 2-entry word buffer plus one possible in-flight read keeps the stream
// gap-free while rk_ready stays high.
// Optional feature macro: RK_XOR_CHECKSUM_EN adds rk_checksum, the running XOR
// of every byte accepted in the current sweep.
module round_key_reader #(
  parameter int NUM_ROUNDS = 10,
  parameter int ADDR_W     = 6
) (
  input  logic gated_clk_ff,
  input  logic rst,
  input  logic start,
  input  logic decrypt,
  input  logic abort,
  round_key_reader_if.master bus,
  output logic busy,
`ifdef RK_XOR_CHECKSUM_EN
  output logic done,
  output logic [7:0] rk_checksum
`else
  output logic done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t state_q, state_d;

  // Sweep direction captured at start
  logic        dec_q;

  // Read-issue position: round and word of the next word to fetch
  logic [3:0]  iss_rnd_q;
  logic [1:0]  iss_word_q;
  logic        inflight_q;

  // Two-entry word buffer
  logic [31:0] buf_mem [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;

  // Output position: byte within the current round key, and its round
  logic [3:0]  pos_q;
  logic [3:0]  round_q;

  logic        start_acc;
  logic [3:0]  fin_rnd;
  logic [1:0]  occ;
  logic        rd_en;
  logic        last_issue;
  logic        rk_valid;
  logic        hs;
  logic        pop;
  logic        push;
  logic        rk_last;
  logic        final_byte;
  logic [31:0] head;
  logic [7:0]  head_byte;

  // Handshake, issue and pop decisions derived from the current state
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch cannot be inferred.
    start_acc  = 1'b0;
    fin_rnd    = dec_q ? 4'd0 : LAST_RND;
    occ        = count_q + {1'b0, inflight_q};
    rd_en      = 1'b0;
    last_issue = 1'b0;
    rk_valid   = (count_q != 2'd0);
    hs         = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    rk_last    = 1'b0;
    final_byte = 1'b0;
    head       = buf_mem[rd_ptr_q];
    head_byte  = 8'h00;

    start_acc  = (state_q == S_IDLE) && start && !abort;
    rd_en      = (state_q == S_RUN) && !abort && (occ < 2'd2);
    last_issue = rd_en && (iss_word_q == 2'd3) && (iss_rnd_q == fin_rnd);
    hs         = rk_valid && bus.rk_ready;
    pop        = hs && (pos_q[1:0] == 2'd3);
    push       = inflight_q && !abort;
    rk_last    = rk_valid && (pos_q == 4'hF);
    final_byte = hs && rk_last && (round_q == fin_rnd);

    unique case (pos_q[1:0])
      2'd0:    head_byte = head[31:24];
      2'd1:    head_byte = head[23:16];
      2'd2:    head_byte = head[15:8];
      default: head_byte = head[7:0];
    endcase
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start)      state_d = S_RUN;
        S_RUN:   if (last_issue) state_d = S_DRAIN;
        S_DRAIN: if (final_byte) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Read-issue position; loaded at start, advanced on each issued read
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    if (!rst) begin
      dec_q      <= 1'b0;
      iss_rnd_q  <= 4'd0;
      iss_word_q <= 2'd0;
    end else if (start_acc) begin
      dec_q      <= decrypt;
      iss_rnd_q  <= decrypt ? LAST_RND : 4'd0;
      iss_word_q <= 2'd0;
    end else if (rd_en) begin
      iss_word_q <= iss_word_q + 2'd1;
      if (iss_word_q == 2'd3 && !last_issue)
        iss_rnd_q <= dec_q ? iss_rnd_q - 4'd1 : iss_rnd_q + 4'd1;
    end
  end

  // In-flight flag: memory data is valid exactly one cycle after the strobe
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    if (!rst) inflight_q <= 1'b0;
    else      inflight_q <= rd_en;
  end

  // Buffer occupancy and pointers; abort empties the buffer
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (abort) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Buffer storage: captures the returning word
  always_ff @(posedge gated_clk_ff) begin
    // NOTE: the data array has no reset; the occupancy count alone says which entries are meaningful.
    if (push) buf_mem[wr_ptr_q] <= bus.mem_rd_data;
  end

  // Output byte position and round index, stepped on each handshake
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    if (!rst) begin
      pos_q   <= 4'd0;
      round_q <= 4'd0;
    end else if (abort) begin
      pos_q   <= 4'd0;
      round_q <= 4'd0;
    end else if (start_acc) begin
      pos_q   <= 4'd0;
      round_q <= decrypt ? LAST_RND : 4'd0;
    end else if (hs) begin
      pos_q <= pos_q + 4'd1;
      if (rk_last && !final_byte)
        round_q <= dec_q ? round_q - 4'd1 : round_q + 4'd1;
    end
  end

`ifdef RK_XOR_CHECKSUM_EN
  logic [7:0] checksum_q;

  // Running XOR of accepted bytes; holds after the sweep until the next start
  always_ff @(posedge gated_clk_ff or negedge rst) begin
    if (!rst)                   checksum_q <= 8'h00;
    else if (abort || start_acc) checksum_q <= 8'h00;
    else if (hs)                checksum_q <= checksum_q ^ head_byte;
  end

  assign rk_checksum = checksum_q;
`endif

  // Output drive; address and byte are forced to zero when not meaningful
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? ADDR_W'({iss_rnd_q, iss_word_q}) : '0;
  assign bus.rk_valid  = rk_valid;
  assign bus.rk_byte   = rk_valid ? head_byte : 8'h00;
  assign bus.rk_last   = rk_last;
  assign bus.round_cnt = round_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_round_key_reader.sv
// Bench for round_key_reader: key memory model mem[i] = {4i,4i+1,4i+2,4i+3},
// an order model of the expected byte/address streams, directed sweeps
// (encrypt, decrypt, backpressure, abort, ignored start, async reset).
module tb_round_key_reader;
  localparam int NR      = 10;
  localparam int AW      = 6;
  localparam int TOTAL_B = 16 * (NR + 1);
  localparam int TOTAL_W = 4 * (NR + 1);

  logic clk = 1'b0;
  logic rst;
  logic start, decrypt, abort;
  logic busy, done;
`ifdef RK_XOR_CHECKSUM_EN
  logic [7:0] rk_checksum;
`endif

  round_key_reader_if #(.ADDR_W(AW)) bus ();

  round_key_reader #(.NUM_ROUNDS(NR), .ADDR_W(AW)) dut (
    .gated_clk_ff (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .abort        (abort),
    .bus          (bus.master),
    .busy         (busy),
`ifdef RK_XOR_CHECKSUM_EN
    .done         (done),
    .rk_checksum  (rk_checksum)
`else
    .done         (done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(int i);
    return {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
  endfunction

  // Registered key memory: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(int'(bus.mem_addr));
  end

  // Order model: which round, byte and word address come k-th in a sweep
  function automatic int exp_round(int k, logic dec);
    return dec ? NR - k / 16 : k / 16;
  endfunction

  function automatic logic [7:0] exp_byte(int k, logic dec);
    return 8'(16 * exp_round(k, dec) + k % 16);
  endfunction

  function automatic int exp_addr(int i, logic dec);
    return 4 * (dec ? NR - i / 4 : i / 4) + i % 4;
  endfunction

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int cfg_gen = 0, seen_gen = 0;
  logic cfg_dec = 1'b0;
  logic armed = 1'b0;
  int acc = 0, iss = 0, last_hs_cyc = -10;
  logic [7:0] xor_acc = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Per-cycle compare of DUT outputs against the order model
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (cfg_gen != seen_gen) begin
        seen_gen    = cfg_gen;
        acc         = 0;
        iss         = 0;
        last_hs_cyc = -10;
        xor_acc     = 8'h00;
      end
      if (!armed || !rst) continue;
      if (bus.mem_rd_en) begin
        if (iss < TOTAL_W) check("mem_addr", 32'(bus.mem_addr), exp_addr(iss, cfg_dec));
        else               check("extra_read", 32'(bus.mem_rd_en), 0);
        iss++;
        check("occupancy_le2", 32'((iss - acc / 4) <= 2), 1);
      end
      if (acc < TOTAL_B) begin
        if (bus.rk_valid) begin
          check("rk_out", {19'd0, bus.rk_byte, bus.rk_last, bus.round_cnt},
                {19'd0, exp_byte(acc, cfg_dec), 1'(acc % 16 == 15), 4'(exp_round(acc, cfg_dec))});
`ifdef RK_XOR_CHECKSUM_EN
          check("checksum_run", 32'(rk_checksum), 32'(xor_acc));
`endif
          if (bus.rk_ready) begin
            xor_acc     = xor_acc ^ exp_byte(acc, cfg_dec);
            acc++;
            last_hs_cyc = cyc;
          end
        end
      end else begin
        check("no_extra_byte", 32'(bus.rk_valid), 0);
      end
      if (done) begin
        check("done_after_bytes", acc, TOTAL_B);
        check("done_latency", cyc - last_hs_cyc, 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sweep(input logic dec);
    cfg_dec = dec;
    cfg_gen++;
    armed   = 1'b1;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
  endtask

  // mode 0: ready high; 1: 1-on/3-off with a 20-cycle hold; 2: ready high plus stray start at byte 50
  task automatic run_to_done(input int mode, input int cyc0, input int budget, output int cycles);
    logic inj;
    inj = 1'b0;
    cycles = cyc0;
    while (!done && cycles < budget) begin
      case (mode)
        1: bus.rk_ready = (cycles % 4 == 0) && !(cycles >= 100 && cycles < 120);
        2: begin
          bus.rk_ready = 1'b1;
          if (acc == 50 && !inj) begin
            start = 1'b1; decrypt = 1'b1; inj = 1'b1;
          end else begin
            start = 1'b0; decrypt = 1'b0;
          end
        end
        default: bus.rk_ready = 1'b1;
      endcase
      tick();
      cycles++;
      if (mode == 2 && inj) check("busy_during_stray_start", 32'(busy || done), 1);
    end
    start = 1'b0;
    decrypt = 1'b0;
    bus.rk_ready = 1'b1;
    check("done_seen", 32'(done), 1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.mem_rd_en, bus.mem_addr, bus.rk_byte, bus.rk_valid,
                bus.rk_last, bus.round_cnt, busy, done});
  endfunction

  initial begin
    int n;
    fork
      monitor_loop();
    join_none

    rst = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
    bus.rk_ready = 1'b0;
    tick(); tick();
    check("reset_outputs", all_outs(), 0);
`ifdef RK_XOR_CHECKSUM_EN
    check("reset_checksum", 32'(rk_checksum), 0);
`endif
    rst = 1'b1;
    tick();
    bus.rk_ready = 1'b1;

    // Encrypt, ready high
    begin_sweep(1'b0);
    check("enc_first_rd", {31'd0, bus.mem_rd_en}, 1);
    check("enc_first_addr", 32'(bus.mem_addr), 0);
    check("enc_valid_c1", 32'(bus.rk_valid), 0);
    check("enc_busy", 32'(busy), 1);
    tick();
    check("enc_valid_c1b", 32'(bus.rk_valid), 0);
    check("enc_second_addr", 32'(bus.mem_addr), 1);
    tick();
    check("enc_first_byte", {bus.rk_valid, bus.rk_byte, bus.round_cnt}, {1'b1, 8'h00, 4'd0});
    run_to_done(0, 2, 400, n);
    check("enc_cycles_to_done", n, 178);
`ifdef RK_XOR_CHECKSUM_EN
    check("enc_checksum", 32'(rk_checksum), 0);
`endif
    tick();
    check("done_one_cycle", {busy, done}, 0);

    // Decrypt, ready high
    begin_sweep(1'b1);
    check("dec_first_addr", 32'(bus.mem_addr), 40);
    tick();
    check("dec_second_addr", 32'(bus.mem_addr), 41);
    tick();
    check("dec_first_byte", {bus.rk_byte, bus.round_cnt}, {8'hA0, 4'd10});
    run_to_done(0, 2, 400, n);
    check("dec_cycles_to_done", n, 178);
    check("dec_final_round", 32'(bus.round_cnt), 0);
    tick();

    // Backpressure
    bus.rk_ready = 1'b0;
    begin_sweep(1'b0);
    run_to_done(1, 0, 3000, n);
    check("bp_all_bytes", acc, TOTAL_B);
`ifdef RK_XOR_CHECKSUM_EN
    check("bp_checksum", 32'(rk_checksum), 0);
`endif
    tick();

    // Abort with a read in flight
    begin_sweep(1'b0);
    n = 0;
    while (!(acc >= 37 && bus.mem_rd_en) && n < 200) begin tick(); n++; end
    check("abort_reached", 32'(acc >= 37), 1);
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_idle", {bus.rk_valid, busy, bus.mem_rd_en}, 0);
`ifdef RK_XOR_CHECKSUM_EN
    check("abort_checksum", 32'(rk_checksum), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_quiet", {bus.rk_valid, busy, done}, 0);
    end
    begin_sweep(1'b0);
    tick(); tick();
    check("restart_byte", {bus.rk_valid, bus.rk_byte}, {1'b1, 8'h00});
    run_to_done(0, 2, 400, n);
    check("restart_cycles", n, 178);
    tick();

    // Stray start while busy
    begin_sweep(1'b0);
    run_to_done(2, 0, 400, n);
    check("stray_start_cycles", n, 178);
    tick();

    // Async reset mid-sweep
    begin_sweep(1'b0);
    n = 0;
    while (acc < 60 && n < 200) begin tick(); n++; end
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
`ifdef RK_XOR_CHECKSUM_EN
    check("async_reset_checksum", 32'(rk_checksum), 0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_idle", all_outs(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
